guess_ctrl: RTL and testbench

GUESS_CTRL -- requirements
Module: guess_ctrl

---
 rtl/guess_pkg.sv | 32 +++
 rtl/pb_debounce.sv | 52 +++++
 rtl/guess_ctrl.sv | 151 +++++++++++++++
 tb/tb_guess_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared constants for the number-guessing controller: state encoding,
// default limits and two-digit BCD helpers.
package guess_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_GUESS = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_WIN   = 3'd4;
    localparam logic [2:0] ST_LOSE  = 3'd5;

    localparam int         MAX_TRIES_DEF  = 9;
    localparam int         DEB_CYCLES_DEF = 16;
    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;

    typedef logic [7:0] bcd2_t;

    function automatic logic bcd_ok(input bcd2_t v);
        return (v[7:4] <= BCD_DIGIT_MAX) && (v[3:0] <= BCD_DIGIT_MAX);
    endfunction

    // Returns {a_gt_b, a_lt_b}; tens digit decides unless equal.
    function automatic logic [1:0] bcd_cmp(input bcd2_t a, input bcd2_t b);
        if (a[7:4] != b[7:4])
            return (a[7:4] > b[7:4]) ? 2'b10 : 2'b01;
        else if (a[3:0] != b[3:0])
            return (a[3:0] > b[3:0]) ? 2'b10 : 2'b01;
        else
            return 2'b00;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter and a
// one-cycle pulse on the clean rising edge.
module pb_debounce
    import guess_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pb,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LP_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_clean;
    logic          r_clean_d;
    logic [CW-1:0] r_cnt;

    // The clean level flips on the DEB_CYCLES-th consecutive differing cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_clean   <= 1'b0;
            r_clean_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_pb;
            r_sync2   <= r_sync1;
            r_clean_d <= r_clean;
            if (r_sync2 != r_clean) begin
                if (r_cnt == LP_LAST) begin
                    r_clean <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_clean;
    assign o_press = r_clean & ~r_clean_d;

endmodule

// File: rtl/guess_ctrl.sv
// Number-guessing game controller: debounced start/stop button, keypad
// guesses compared against a captured BCD target, win/lose tracking.
module guess_ctrl
    import guess_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int MAX_TRIES  = MAX_TRIES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PB,
    input  logic       key_valid,
    input  logic [7:0] key_bcd,
    input  logic [7:0] cnt_bcd,
    output logic       cnt_en,
    output logic [7:0] disp_bcd,
    output logic       disp_on,
    output logic       too_high,
    output logic       too_low,
    output logic       hit,
    output logic [3:0] attempts,
    output logic       done,
    output logic [2:0] dbg_state
);

    localparam logic [3:0] LP_MAX = 4'(MAX_TRIES);

    logic       w_pb_press;
    logic       w_pb_level;
    logic       w_key_evt;
    logic [1:0] w_cmp;
    logic [3:0] w_att_next;

    logic       r_key_s1;
    logic       r_key_s2;
    logic       r_key_s3;
    logic [2:0] r_state;
    bcd2_t      r_target;
    bcd2_t      r_guess;
    logic       r_hit;
    logic       r_hi;
    logic       r_lo;
    logic [3:0] r_attempts;

    pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pb    (PB),
        .o_level (w_pb_level),
        .o_press (w_pb_press)
    );

    assign w_key_evt  = r_key_s2 & ~r_key_s3;
    assign w_cmp      = bcd_cmp(r_guess, r_target);
    assign w_att_next = r_attempts + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_s1   <= 1'b0;
            r_key_s2   <= 1'b0;
            r_key_s3   <= 1'b0;
            r_state    <= ST_IDLE;
            r_target   <= '0;
            r_guess    <= '0;
            r_hit      <= 1'b0;
            r_hi       <= 1'b0;
            r_lo       <= 1'b0;
            r_attempts <= '0;
        end else begin
            r_key_s1 <= key_valid;
            r_key_s2 <= r_key_s1;
            r_key_s3 <= r_key_s2;
            case (r_state)
                ST_IDLE: begin
                    if (w_pb_press) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_pb_press) begin
                        r_target   <= cnt_bcd;
                        r_guess    <= '0;
                        r_attempts <= '0;
                        {r_hit, r_hi, r_lo} <= 3'b000;
                        r_state    <= ST_GUESS;
                    end
                end
                ST_GUESS: begin
                    // An abort press wins over a key arriving in the same cycle.
                    if (w_pb_press) begin
                        r_attempts <= '0;
                        {r_hit, r_hi, r_lo} <= 3'b000;
                        r_state    <= ST_IDLE;
                    end else if (w_key_evt && bcd_ok(key_bcd)) begin
                        r_guess <= key_bcd;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_hit <= (w_cmp == 2'b00);
                    r_hi  <= w_cmp[1];
                    r_lo  <= w_cmp[0];
                    if (w_cmp == 2'b00) begin
                        r_state <= ST_WIN;
                    end else begin
                        r_attempts <= w_att_next;
                        r_state    <= (w_att_next == LP_MAX) ? ST_LOSE : ST_GUESS;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (w_pb_press) begin
                        r_attempts <= '0;
                        {r_hit, r_hi, r_lo} <= 3'b000;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_en   = 1'b0;
        disp_on  = 1'b0;
        disp_bcd = 8'h00;
        done     = 1'b0;
        case (r_state)
            ST_RUN: cnt_en = 1'b1;
            ST_GUESS, ST_CHECK: begin
                disp_on  = 1'b1;
                disp_bcd = r_guess;
            end
            ST_WIN: begin
                disp_on  = 1'b1;
                disp_bcd = r_guess;
                done     = 1'b1;
            end
            ST_LOSE: begin
                disp_on  = 1'b1;
                disp_bcd = r_target;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign hit       = r_hit;
    assign too_high  = r_hi;
    assign too_low   = r_lo;
    assign attempts  = r_attempts;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_guess_ctrl.sv
// Directed bench for guess_ctrl: table of keypad vectors plus hand-written
// sequences for bounce, timing, lose, abort and reset corners.
module tb_guess_ctrl;
    import guess_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PB = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_bcd = 8'h00;
    logic [7:0] cnt_bcd = 8'h00;
    logic       cnt_en;
    logic [7:0] disp_bcd;
    logic       disp_on;
    logic       too_high;
    logic       too_low;
    logic       hit;
    logic [3:0] attempts;
    logic       done;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int pb_pulses = 0;
    int coinc = 0;

    guess_ctrl #(.DEB_CYCLES(16), .MAX_TRIES(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .PB        (PB),
        .key_valid (key_valid),
        .key_bcd   (key_bcd),
        .cnt_bcd   (cnt_bcd),
        .cnt_en    (cnt_en),
        .disp_bcd  (disp_bcd),
        .disp_on   (disp_on),
        .too_high  (too_high),
        .too_low   (too_low),
        .hit       (hit),
        .attempts  (attempts),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.w_pb_press) pb_pulses++;
        if (dut.w_pb_press && dut.w_key_evt) coinc++;
    end

    typedef struct {
        logic [7:0] key;
        int         hold;
        logic [2:0] st;
        logic [2:0] flags;   // {too_high, too_low, hit}
        logic [3:0] att;
        logic [7:0] disp;
        logic       done;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic press_pb();
        @(negedge clk) PB = 1'b1;
        repeat (24) @(negedge clk);
        PB = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic press_pb_bouncy();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) PB = ~PB;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        PB = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic press_key(input logic [7:0] v, input int hold);
        @(negedge clk);
        key_bcd   = v;
        key_valid = 1'b1;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_state"},  32'(dbg_state), 32'(ST_IDLE));
        chk({tag, "_cnt_en"}, 32'(cnt_en), 32'd0);
        chk({tag, "_disp"},   32'({disp_on, disp_bcd}), 32'h000);
        chk({tag, "_flags"},  32'({too_high, too_low, hit}), 32'd0);
        chk({tag, "_att"},    32'(attempts), 32'd0);
        chk({tag, "_done"},   32'(done), 32'd0);
    endtask

    initial begin
        tbl[0] = '{8'h30, 50, ST_GUESS, 3'b010, 4'd2, 8'h30, 1'b0};
        tbl[1] = '{8'h3A,  6, ST_GUESS, 3'b010, 4'd2, 8'h30, 1'b0};
        tbl[2] = '{8'hA5,  6, ST_GUESS, 3'b010, 4'd2, 8'h30, 1'b0};
        tbl[3] = '{8'h47,  6, ST_WIN,   3'b001, 4'd2, 8'h47, 1'b1};
        tbl[4] = '{8'h12,  6, ST_WIN,   3'b001, 4'd2, 8'h47, 1'b1};

        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // bouncing press: one pulse, IDLE -> RUN
        pb_pulses = 0;
        press_pb_bouncy();
        chk("bounce_pulses", 32'(pb_pulses), 32'd1);
        chk("bounce_state",  32'(dbg_state), 32'(ST_RUN));
        chk("run_cnt_en",    32'(cnt_en), 32'd1);
        chk("run_disp_on",   32'(disp_on), 32'd0);

        // start game with target 47
        cnt_bcd = 8'h47;
        press_pb();
        chk("guess_state", 32'(dbg_state), 32'(ST_GUESS));
        chk("guess_disp",  32'({disp_on, disp_bcd}), 32'h100);
        chk("guess_cnt_en", 32'(cnt_en), 32'd0);
        cnt_bcd = 8'h99;

        // key 52: CHECK on 3rd edge, flags on 4th
        @(negedge clk);
        key_bcd = 8'h52;
        key_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t52_check_state", 32'(dbg_state), 32'(ST_CHECK));
        chk("t52_pre_flags",   32'({too_high, too_low, hit, attempts}), 32'h00);
        @(negedge clk);
        chk("t52_flags", 32'({too_high, too_low, hit}), 32'b100);
        chk("t52_att",   32'(attempts), 32'd1);
        chk("t52_state", 32'(dbg_state), 32'(ST_GUESS));
        key_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("t52_disp", 32'(disp_bcd), 32'h52);

        for (int i = 0; i < 5; i++) begin
            press_key(tbl[i].key, tbl[i].hold);
            chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_flags", i), 32'({too_high, too_low, hit}), 32'(tbl[i].flags));
            chk($sformatf("vec%0d_att", i),   32'(attempts), 32'(tbl[i].att));
            chk($sformatf("vec%0d_disp", i),  32'(disp_bcd), 32'(tbl[i].disp));
            chk($sformatf("vec%0d_done", i),  32'(done), 32'(tbl[i].done));
        end

        press_pb();
        chk_reset_outs("win_exit");

        // lose game: target 05, nine guesses of 06
        press_pb();
        cnt_bcd = 8'h05;
        press_pb();
        for (int i = 1; i <= 10; i++) begin
            press_key(8'h06, 5);
            chk($sformatf("lose%0d_att", i), 32'(attempts), (i >= 9) ? 32'd9 : 32'(i));
            chk($sformatf("lose%0d_state", i), 32'(dbg_state), (i >= 9) ? 32'(ST_LOSE) : 32'(ST_GUESS));
            chk($sformatf("lose%0d_flags", i), 32'({too_high, too_low, hit}), 32'b100);
        end
        chk("lose_disp", 32'({disp_on, disp_bcd}), 32'h105);
        chk("lose_done", 32'(done), 32'd1);
        press_pb();
        chk_reset_outs("lose_exit");

        // abort: pb_press and key_evt in the same cycle
        press_pb();
        cnt_bcd = 8'h20;
        press_pb();
        press_key(8'h25, 5);
        chk("abort_pre_att", 32'(attempts), 32'd1);
        coinc = 0;
        @(negedge clk) PB = 1'b1;
        repeat (16) @(negedge clk);
        key_bcd = 8'h20;
        key_valid = 1'b1;
        repeat (8) @(negedge clk);
        PB = 1'b0;
        key_valid = 1'b0;
        repeat (24) @(negedge clk);
        chk("abort_coinc", 32'(coinc), 32'd1);
        chk_reset_outs("abort");

        // reset asserted while in CHECK
        press_pb();
        press_pb();
        @(negedge clk);
        key_bcd = 8'h33;
        key_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstchk_state", 32'(dbg_state), 32'(ST_CHECK));
        #1 rst = 1'b1;
        #1 chk_reset_outs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        key_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk_reset_outs("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
